pwm_ramp_ctrl: RTL

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_frame_timer.sv | 35 +++
 rtl/pwm_ramp_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and default widths for the PWM ramp controller
package pwm_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_frame_timer.sv
// rtl/pwm_frame_timer.sv - frame counter mirroring the downstream PWM counter, flags the last cycle of each frame
module pwm_frame_timer
    import pwm_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] period,
    output logic         frame_end
);

    logic [W-1:0] count;
    logic [W-1:0] last;

    // periods of 0 and 1 both collapse to a one-cycle frame with the counter parked at 0
    always_comb begin
        last = (period > W'(1)) ? period - W'(1) : '0;
    end

    assign frame_end = (count == last);

    // counter wraps at the end of each frame and is held at 0 while cleared
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (frame_end) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - ramps PWM duty toward a requested target; PWM_SOFT_STOP_EN enables ramp-down on stop
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     period_in,
    input  logic [W-1:0]     target_in,
    input  logic             target_valid,
    output logic             target_ready,
    input  logic [W-1:0]     step,
    input  logic [DIV_W-1:0] frames_per_step,
    output logic [W-1:0]     duty_cycle,
    output logic [W-1:0]     period,
    output logic             busy,
    output logic             at_target
);

    // where the machine goes when en drops while driving the PWM
`ifdef PWM_SOFT_STOP_EN
    localparam pwm_state_t EN_OFF_STATE = STOP;
`else
    localparam pwm_state_t EN_OFF_STATE = IDLE;
`endif

    pwm_state_t       state;
    pwm_state_t       state_next;

    logic [W-1:0]     duty_q;
    logic [W-1:0]     duty_next;
    logic [W-1:0]     period_q;
    logic [W-1:0]     period_next;
    logic [W-1:0]     tgt_q;
    logic [W-1:0]     tgt_next;
    logic [W-1:0]     clamp_val;
    logic [W-1:0]     step_eff;
    logic [W-1:0]     goal;
    logic [W-1:0]     toward;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] div_last;

    logic             handshake;
    logic             accept;
    logic             driving;
    logic             frame_end;
    logic             tick;
    logic             timer_clear;

    // the frame counter only runs while the PWM is being driven
    assign timer_clear = (state == IDLE) || (state_next == IDLE);

    pwm_frame_timer #(
        .W(W)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .period    (period_q),
        .frame_end (frame_end)
    );

    // target acceptance: clamp against the period that will be active after this cycle
    always_comb begin
        driving     = (state == RAMP) || (state == HOLD);
        handshake   = target_valid && target_ready;
        period_next = (state == IDLE) ? period_in : period_q;
        clamp_val   = (target_in > period_next) ? period_next : target_in;
        accept      = handshake && !(driving && !en);
        tgt_next    = accept ? clamp_val : tgt_q;
    end

    // step pacing and the saturating move of duty toward the current goal
    always_comb begin
        step_eff = (step == '0) ? W'(1) : step;
        div_last = (frames_per_step == '0) ? '0 : frames_per_step - DIV_W'(1);
        tick     = frame_end && (div_q >= div_last) && ((state == RAMP) || (state == STOP));
        goal     = (state == STOP) ? '0 : tgt_next;
        if (duty_q < goal) begin
            toward = (goal - duty_q <= step_eff) ? goal : duty_q + step_eff;
        end else if (duty_q > goal) begin
            toward = (duty_q - goal <= step_eff) ? goal : duty_q - step_eff;
        end else begin
            toward = duty_q;
        end
    end

    // frame divider counts frame ends while ramping and survives target redirects
    always_comb begin
        div_next = '0;
        if ((state == RAMP) || (state == STOP)) begin
            if (tick) begin
                div_next = '0;
            end else if (frame_end) begin
                div_next = div_q + DIV_W'(1);
            end else begin
                div_next = div_q;
            end
        end
    end

    // next duty value: zero in IDLE, steps only on paced frame ends
    always_comb begin
        duty_next = duty_q;
        if (state == IDLE) begin
            duty_next = '0;
        end else if (state == STOP) begin
`ifdef PWM_SOFT_STOP_EN
            if (!en && tick) begin
                duty_next = toward;
            end
`else
            duty_next = '0;
`endif
        end else if (!en) begin
`ifndef PWM_SOFT_STOP_EN
            duty_next = '0;
`endif
        end else if ((state == RAMP) && tick) begin
            duty_next = toward;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decision; en low outranks any target offered in the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RAMP;
                end
            end
            RAMP: begin
                if (!en) begin
                    state_next = EN_OFF_STATE;
                end else if (duty_q == tgt_next) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!en) begin
                    state_next = EN_OFF_STATE;
                end else if (duty_q != tgt_next) begin
                    state_next = RAMP;
                end
            end
            STOP: begin
`ifdef PWM_SOFT_STOP_EN
                if (en) begin
                    state_next = RAMP;
                end else if (duty_q == '0) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // status outputs, all forced low while reset is held
    always_comb begin
        target_ready = !rst && (state != STOP);
        busy         = !rst && (state != IDLE);
        at_target    = !rst && (state == HOLD) && (duty_q == tgt_q);
    end

    // datapath registers: duty, frozen period, latched target and divider
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q   <= '0;
            period_q <= '0;
            tgt_q    <= '0;
            div_q    <= '0;
        end else begin
            duty_q   <= duty_next;
            period_q <= period_next;
            tgt_q    <= tgt_next;
            div_q    <= div_next;
        end
    end

    assign duty_cycle = duty_q;
    assign period     = period_q;

endmodule
